// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the IC/DC main-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IC = 1'b0,
        GNT_DC = 1'b1
    } gnt_id_t;

    localparam int LINE_WORDS = 4;

    // Word address of the first word of the line holding addr.
    function automatic logic [31:0] line_addr(input logic [31:0] addr);
        return addr & ~32'(LINE_WORDS - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin pick; last_grant is held by the parent.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic    en,
    input  logic    req_ic,
    input  logic    req_dc,
    input  gnt_id_t last_grant,
    output gnt_id_t gnt_id,
    output logic    gnt_valid
);

    // A sole requester wins; a tie goes to the port not granted last.
    always_comb begin
        gnt_id    = GNT_IC;
        gnt_valid = 1'b0;
        if (en) begin
            if (req_ic && req_dc) begin
                gnt_valid = 1'b1;
                gnt_id    = (last_grant == GNT_IC) ? GNT_DC : GNT_IC;
            end else if (req_ic) begin
                gnt_valid = 1'b1;
                gnt_id    = GNT_IC;
            end else if (req_dc) begin
                gnt_valid = 1'b1;
                gnt_id    = GNT_DC;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares main memory between the IC refill port and the DC port.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; arbitrate and latch the winner's request
// BUSY  | memory beats 0..LATENCY-1 for the granted port
// RESP  | line registered, granted port's done high for this one cycle
//
// All outputs are registered: the output process computes the value each
// output takes in the next state, and a register stage applies it, so no
// req input reaches an output combinationally.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ic_req,
    input  logic [ADDR_W-1:0]            ic_addr,
    output logic [LINE_WORDS*DATA_W-1:0] ic_line,
    output logic                         ic_done,
    input  logic                         dc_req,
    input  logic                         dc_we,
    input  logic [ADDR_W-1:0]            dc_addr,
    input  logic [DATA_W-1:0]            dc_wdata,
    output logic [LINE_WORDS*DATA_W-1:0] dc_line,
    output logic                         dc_done,
    output logic                         busy,
    output logic [ADDR_W-1:0]            mem_address,
    output logic [DATA_W-1:0]            mem_data_in,
    output logic                         mem_write,
    output logic                         mem_waring,
    input  logic [LINE_WORDS*DATA_W-1:0] mem_read_value
);

    localparam int         LINE_W    = LINE_WORDS * DATA_W;
    localparam logic [3:0] LAST_BEAT = 4'(LATENCY - 1);

    arb_state_t        state, state_nxt;
    logic [3:0]        beat, beat_nxt;
    gnt_id_t           last_grant, last_grant_nxt;
    gnt_id_t           gnt_q, gnt_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              we_q, we_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;

    gnt_id_t           arb_id;
    logic              arb_valid;
    logic              line_done;

    logic              busy_nxt;
    logic              ic_done_nxt;
    logic              dc_done_nxt;
    logic              mem_write_nxt;
    logic              mem_waring_nxt;
    logic [ADDR_W-1:0] mem_address_nxt;
    logic [DATA_W-1:0] mem_data_in_nxt;
    logic [LINE_W-1:0] ic_line_nxt;
    logic [LINE_W-1:0] dc_line_nxt;

    rr_arbiter2 u_rr (
        .en         (state == IDLE),
        .req_ic     (ic_req),
        .req_dc     (dc_req),
        .last_grant (last_grant),
        .gnt_id     (arb_id),
        .gnt_valid  (arb_valid)
    );

    assign line_done = (state == BUSY) && (beat == LAST_BEAT);

    // State register plus the request fields latched at grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat       <= '0;
            last_grant <= GNT_DC;
            gnt_q      <= GNT_IC;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state      <= state_nxt;
            beat       <= beat_nxt;
            last_grant <= last_grant_nxt;
            gnt_q      <= gnt_nxt;
            addr_q     <= addr_nxt;
            we_q       <= we_nxt;
            wdata_q    <= wdata_nxt;
        end
    end

    // Next state: grant in IDLE, count beats in BUSY, single RESP cycle.
    always_comb begin
        state_nxt      = state;
        beat_nxt       = beat;
        last_grant_nxt = last_grant;
        gnt_nxt        = gnt_q;
        addr_nxt       = addr_q;
        we_nxt         = we_q;
        wdata_nxt      = wdata_q;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt      = BUSY;
                    beat_nxt       = '0;
                    gnt_nxt        = arb_id;
                    last_grant_nxt = arb_id;
                    wdata_nxt      = dc_wdata;
                    if (arb_id == GNT_IC) begin
                        addr_nxt = ic_addr;
                        we_nxt   = 1'b0;
                    end else begin
                        addr_nxt = dc_addr;
                        we_nxt   = dc_we;
                    end
                end
            end
            BUSY: begin
                if (beat == LAST_BEAT) begin
                    state_nxt = RESP;
                end else begin
                    beat_nxt = beat + 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin
        busy_nxt        = (state_nxt != IDLE);
        mem_write_nxt   = 1'b0;
        mem_waring_nxt  = 1'b0;
        mem_address_nxt = mem_address;
        mem_data_in_nxt = mem_data_in;
        if (state_nxt == BUSY) begin
            if (we_nxt) begin
                // A write puts its single word out on beat 0, then waits.
                if (beat_nxt == 4'd0) begin
                    mem_write_nxt   = 1'b1;
                    mem_address_nxt = addr_nxt;
                    mem_data_in_nxt = wdata_nxt;
                end else begin
                    mem_waring_nxt = 1'b1;
                end
            end else begin
                mem_waring_nxt  = 1'b1;
                mem_address_nxt = ADDR_W'(line_addr(32'(addr_nxt)));
            end
        end
        ic_done_nxt = (state_nxt == RESP) && (gnt_nxt == GNT_IC);
        dc_done_nxt = (state_nxt == RESP) && (gnt_nxt == GNT_DC);
        ic_line_nxt = ic_line;
        dc_line_nxt = dc_line;
        if (line_done && !we_q) begin
            if (gnt_q == GNT_IC) begin
                ic_line_nxt = mem_read_value;
            end else begin
                dc_line_nxt = mem_read_value;
            end
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            ic_done     <= 1'b0;
            dc_done     <= 1'b0;
            mem_write   <= 1'b0;
            mem_waring  <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            ic_line     <= '0;
            dc_line     <= '0;
        end else begin
            busy        <= busy_nxt;
            ic_done     <= ic_done_nxt;
            dc_done     <= dc_done_nxt;
            mem_write   <= mem_write_nxt;
            mem_waring  <= mem_waring_nxt;
            mem_address <= mem_address_nxt;
            mem_data_in <= mem_data_in_nxt;
            ic_line     <= ic_line_nxt;
            dc_line     <= dc_line_nxt;
        end
    end

endmodule
